ex_div: RTL

//  Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, inside the EX stage downstream of id_ex.
//  EX launches it with the operands and rd address from id_ex, then holds the pipeline through busy_o.
//  It returns one quotient/remainder per operation, with a one-cycle ready_o pulse.

---
 rtl/ex_div.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Latency: 32 steps after launch (ready_o in the cycle after the last step); divide-by-zero and overflow finish in 1.
// Backpressure: busy_o holds the pipeline from launch through CALC; flush_i aborts silently; start_i ignored outside IDLE.
module ex_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      reg_waddr_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;        // partial remainder
  logic [XLEN-1:0] quot_q, quot_d;      // dividend magnitude shifting out, quotient bits shifting in
  logic [XLEN-1:0] dvs_q, dvs_d;        // divisor magnitude
  logic            want_rem_q, want_rem_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic [4:0]      rd_q, rd_d;          // rd of the op in flight
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      waddr_q, waddr_d;    // rd of the last completed op

  // Operand decode at launch: signedness, magnitudes and the two special cases
  logic            signed_op, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    signed_op = op_i[2] & ~op_i[0];
    a_neg     = signed_op & dividend_i[XLEN-1];
    b_neg     = signed_op & divisor_i[XLEN-1];
    a_mag     = a_neg ? -dividend_i : dividend_i;
    b_mag     = b_neg ? -divisor_i : divisor_i;
    div_zero  = (divisor_i == '0);
    ovf       = signed_op && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_i == '1);
  end

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore
  logic [XLEN:0]   rem_shift, trial;
  logic            q_bit;
  logic [XLEN-1:0] rem_step, quot_step, quot_fix, rem_fix;

  always_comb begin
    rem_shift = {rem_q, quot_q[XLEN-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    q_bit     = ~trial[XLEN];
    rem_step  = q_bit ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
    quot_step = {quot_q[XLEN-2:0], q_bit};
    quot_fix  = neg_quot_q ? -quot_step : quot_step;
    rem_fix   = neg_rem_q ? -rem_step : rem_step;
  end

  // Next-state and datapath control; flush wins over launch and over completion
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvs_d      = dvs_q;
    want_rem_d = want_rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    rd_d       = rd_q;
    result_d   = result_q;
    waddr_d    = waddr_q;
    case (state_q)
      S_IDLE: begin
        if (!flush_i && start_i) begin
          want_rem_d = op_i[1];
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          quot_d     = a_mag;
          dvs_d      = b_mag;
          rem_d      = '0;
          cnt_d      = '0;
          rd_d       = reg_waddr_i;
          if (div_zero) begin
            result_d = op_i[1] ? dividend_i : '1;
            waddr_d  = reg_waddr_i;
            state_d  = S_DONE;
          end else if (ovf) begin
            result_d = op_i[1] ? '0 : dividend_i;
            waddr_d  = reg_waddr_i;
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = rem_step;
          quot_d = quot_step;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            result_d = want_rem_q ? rem_fix : quot_fix;
            waddr_d  = rd_q;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      want_rem_q <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
      waddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvs_q      <= dvs_d;
      want_rem_q <= want_rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      waddr_q    <= waddr_d;
    end
  end

  // Hold is combinational so id_ex freezes in the launch cycle; released in DONE
  always_comb begin
    busy_o      = ((state_q == S_IDLE) && start_i && !flush_i) || (state_q == S_CALC);
    ready_o     = (state_q == S_DONE);
    result_o    = result_q;
    reg_waddr_o = waddr_q;
  end

endmodule
